// File: rtl/filtro_conv_pkg.sv
// Shared types and constants for the parametrised 3x3 convolution peripheral.
package filtro_conv_pkg;

  // Kernel selection; encoding 2'd3 is reserved and treated as identity.
  typedef enum logic [1:0] {
    MODE_GAUSS = 2'd0,
    MODE_IDENT = 2'd1,
    MODE_EDGE  = 2'd2
  } conv_mode_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_NORM  = 2'd2
  } conv_state_t;

  // Register map.
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_RESULT = 2'd2;

  // CTRL bit positions (write side).
  localparam int CTRL_START    = 0;
  localparam int CTRL_MODE_LO  = 1;
  localparam int CTRL_MODE_HI  = 2;
  localparam int CTRL_CLR_PTR  = 3;
  localparam int CTRL_IRQ_EN   = 4;
  localparam int CTRL_DONE_CLR = 5;

  // CTRL bit positions (read side).
  localparam int CTRL_BUSY   = 0;
  localparam int CTRL_DONE   = 8;
  localparam int CTRL_PTR_LO = 12;
  localparam int CTRL_PTR_HI = 15;

  // Window geometry.
  localparam int          N_TAPS   = 9;
  localparam logic [3:0]  LAST_TAP = 4'd8;
  localparam logic [3:0]  CTR_TAP  = 4'd4;

endpackage

// File: rtl/conv_coef_rom.sv
// Kernel coefficient lookup: (mode, tap index) -> signed 5-bit weight.
module conv_coef_rom
  import filtro_conv_pkg::*;
(
  input  logic [1:0]        mode,
  input  logic [3:0]        idx,
  output logic signed [4:0] coef
);

  // Pure table lookup; out-of-window indices weigh zero.
  always_comb begin
    coef = 5'sd0;
    case (mode)
      MODE_GAUSS: begin
        case (idx)
          4'd0, 4'd2, 4'd6, 4'd8: coef = 5'sd1;
          4'd1, 4'd3, 4'd5, 4'd7: coef = 5'sd2;
          4'd4:                   coef = 5'sd4;
          default:                coef = 5'sd0;
        endcase
      end
      MODE_EDGE: begin
        if (idx == CTR_TAP)      coef = 5'sd8;
        else if (idx <= LAST_TAP) coef = -5'sd1;
        else                     coef = 5'sd0;
      end
      default: begin
        // identity and the reserved encoding both pass the centre through
        coef = (idx == CTR_TAP) ? 5'sd1 : 5'sd0;
      end
    endcase
  end

endmodule

// File: rtl/filtro_conv3x3_param.sv
// Memory-mapped 3x3 convolution unit: nine-pixel window, three kernel modes,
// sequential multiply-accumulate over 9 cycles, saturating result, sticky done
// flag and level interrupt.
//
// Bus handshake: a register access is a single cycle; a write takes effect on
// the rising edge where we=1, reads are a pure combinational mux of registers
// (no strobe), so there is no valid/ready back-pressure on this port.
module filtro_conv3x3_param
  import filtro_conv_pkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter bit ROUND   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  addr_i,
  input  logic [31:0] entrada_i,
  output logic [31:0] salida_o,
  output logic        irq_o
);

  localparam int ACC_W = PIXEL_W + 5;
  localparam logic [PIXEL_W-1:0]      PIX_MAX = '1;
  localparam logic signed [ACC_W-1:0] SAT_HI  = {5'b0, PIX_MAX};
  localparam logic signed [ACC_W-1:0] RND_ADD = ROUND ? ACC_W'(8) : '0;

  // registers
  logic [PIXEL_W-1:0]      win [N_TAPS];
  logic [3:0]              ptr;
  logic [1:0]              mode_q;
  logic                    irq_en;
  logic                    done;
  logic [PIXEL_W-1:0]      result;
  logic signed [ACC_W-1:0] acc;
  logic [3:0]              idx;
  conv_state_t             state;
  conv_state_t             state_nxt;

  // decoded controls
  logic ctrl_wr;
  logic data_wr;
  logic start_go;
  logic busy;
  logic acc_en;
  logic norm_en;

  // datapath nets
  logic [PIXEL_W-1:0]      tap_pix;
  logic [PIXEL_W-1:0]      rd_pix;
  logic signed [4:0]       coef;
  logic signed [ACC_W-1:0] coef_ext;
  logic signed [ACC_W-1:0] pix_ext;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] shaped;
  logic [PIXEL_W-1:0]      sat;
  logic                    unused_wdata;

  assign ctrl_wr  = we && (addr_i == ADDR_CTRL);
  assign data_wr  = we && (addr_i == ADDR_DATA);
  assign start_go = ctrl_wr && entrada_i[CTRL_START] && !busy;
  // the write-data word is only partly decoded; fold it to one sink bit
  assign unused_wdata = ^entrada_i;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state: one accumulate cycle per tap, then one normalise cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_go) state_nxt = ST_ACCUM;
      ST_ACCUM: if (idx == LAST_TAP) state_nxt = ST_NORM;
      ST_NORM:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    busy    = (state != ST_IDLE);
    acc_en  = (state == ST_ACCUM);
    norm_en = (state == ST_NORM);
  end

  // tap selected by the accumulate index and by the bus pointer
  always_comb begin
    tap_pix = '0;
    rd_pix  = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      if (idx == i[3:0]) tap_pix = win[i];
      if (ptr == i[3:0]) rd_pix  = win[i];
    end
  end

  conv_coef_rom u_coef_rom (
    .mode (mode_q),
    .idx  (idx),
    .coef (coef)
  );

  // signed multiply-accumulate; pixels are unsigned so they are zero-extended
  always_comb begin
    coef_ext = {{(ACC_W-5){coef[4]}}, coef};
    pix_ext  = {5'b0, tap_pix};
    acc_nxt  = acc + coef_ext * pix_ext;
  end

  // mode-specific normalisation followed by saturation to the pixel range
  always_comb begin
    case (mode_q)
      MODE_GAUSS: shaped = (acc + RND_ADD) >>> 4;
      MODE_EDGE:  shaped = acc[ACC_W-1] ? -acc : acc;
      default:    shaped = acc;
    endcase
    if (shaped[ACC_W-1])    sat = '0;
    else if (shaped > SAT_HI) sat = PIX_MAX;
    else                    sat = shaped[PIXEL_W-1:0];
  end

  // accumulator and tap index
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
      idx <= '0;
    end else if (start_go) begin
      acc <= '0;
      idx <= '0;
    end else if (acc_en) begin
      acc <= acc_nxt;
      idx <= idx + 4'd1;
    end
  end

  // control/status registers; completion beats a same-edge done clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q <= '0;
      irq_en <= 1'b0;
      done   <= 1'b0;
      ptr    <= '0;
    end else begin
      if (start_go) mode_q <= entrada_i[CTRL_MODE_HI:CTRL_MODE_LO];
      if (ctrl_wr)  irq_en <= entrada_i[CTRL_IRQ_EN];

      if (norm_en)                                done <= 1'b1;
      else if (start_go)                          done <= 1'b0;
      else if (ctrl_wr && entrada_i[CTRL_DONE_CLR]) done <= 1'b0;

      if (ctrl_wr && entrada_i[CTRL_CLR_PTR]) ptr <= '0;
      else if (data_wr && !busy)              ptr <= (ptr == LAST_TAP) ? 4'd0 : ptr + 4'd1;
    end
  end

  // pixel window, frozen while a run is in progress
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_TAPS; i++) win[i] <= '0;
    end else if (data_wr && !busy) begin
      for (int i = 0; i < N_TAPS; i++)
        if (ptr == i[3:0]) win[i] <= entrada_i[PIXEL_W-1:0];
    end
  end

  // result register, loaded in the normalise cycle
  always_ff @(posedge clk) begin
    if (!rst)         result <= '0;
    else if (norm_en) result <= sat;
  end

  // read mux of registered state
  always_comb begin
    salida_o = '0;
    case (addr_i)
      ADDR_CTRL: begin
        salida_o[CTRL_BUSY]                 = busy;
        salida_o[CTRL_MODE_HI:CTRL_MODE_LO] = mode_q;
        salida_o[CTRL_IRQ_EN]               = irq_en;
        salida_o[CTRL_DONE]                 = done;
        salida_o[CTRL_PTR_HI:CTRL_PTR_LO]   = ptr;
      end
      ADDR_DATA:   salida_o[PIXEL_W-1:0] = rd_pix;
      ADDR_RESULT: salida_o[PIXEL_W-1:0] = result;
      default:     salida_o = '0;
    endcase
  end

  // level interrupt
  always_comb irq_o = done & irq_en;

endmodule

// File: tb/tb_filtro_conv3x3_param.sv
// Bench for filtro_conv3x3_param: two instances share one bus, an 8-bit
// truncating unit (a) and a 12-bit rounding unit (b). Reads push expected
// values into queues; a negedge monitor pops and compares.
module tb_filtro_conv3x3_param;
  import filtro_conv_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        irq_a, irq_b;

  filtro_conv3x3_param #(.PIXEL_W(8), .ROUND(1'b0)) dut_a (
    .clk(clk), .rst(rst), .we(we), .addr_i(addr), .entrada_i(wdata),
    .salida_o(rdata_a), .irq_o(irq_a)
  );

  filtro_conv3x3_param #(.PIXEL_W(12), .ROUND(1'b1)) dut_b (
    .clk(clk), .rst(rst), .we(we), .addr_i(addr), .entrada_i(wdata),
    .salida_o(rdata_b), .irq_o(irq_b)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] exp_b_q[$];
  logic        exp_irq_q[$];
  string       name_q[$];
  int          checks_total  = 0;
  int          checks_passed = 0;
  logic        rd_pend = 1'b0;

  string       mon_name;
  logic [31:0] mon_ea, mon_eb;
  logic        mon_ei;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // monitor: compares every presented read against the queued expectation
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        checks_total++;
        $display("FAIL monitor: read presented with empty expected queue");
      end else begin
        mon_name = name_q.pop_front();
        mon_ea   = exp_q.pop_front();
        mon_eb   = exp_b_q.pop_front();
        mon_ei   = exp_irq_q.pop_front();
        check({mon_name, "_a"}, rdata_a, mon_ea);
        check({mon_name, "_b"}, rdata_b, mon_eb);
        check({mon_name, "_irq_a"}, {31'b0, irq_a}, {31'b0, mon_ei});
        check({mon_name, "_irq_b"}, {31'b0, irq_b}, {31'b0, mon_ei});
      end
    end
  end

  // driver tasks (entered and left at posedge+1)
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] ea, input logic [31:0] eb,
                    input logic ei, input string n);
    exp_q.push_back(ea);
    exp_b_q.push_back(eb);
    exp_irq_q.push_back(ei);
    name_q.push_back(n);
    addr    = a;
    rd_pend = 1'b1;
    @(posedge clk);
    #1;
    rd_pend = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // fills the window from ptr=0: centre c, all eight neighbours n
  task automatic load9(input logic [31:0] c, input logic [31:0] n);
    for (int i = 0; i < 9; i++) wr(ADDR_DATA, (i == 4) ? c : n);
  endtask

  // watchdog
  initial begin
    #200000;
    checks_total++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // stimulus
  initial begin
    rst = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // reset state
    rd(ADDR_CTRL,   32'h0, 32'h0, 1'b0, "rst_ctrl");
    rd(ADDR_DATA,   32'h0, 32'h0, 1'b0, "rst_data");
    rd(ADDR_RESULT, 32'h0, 32'h0, 1'b0, "rst_result");
    rd(2'd3,        32'h0, 32'h0, 1'b0, "rst_addr3");

    // Gaussian uniform window, exact 10-cycle latency
    load9(32'd100, 32'd100);
    wr(ADDR_CTRL, 32'h01);
    idle(8);
    rd(ADDR_CTRL, 32'h001, 32'h001, 1'b0, "busy_before_e9");
    rd(ADDR_CTRL, 32'h001, 32'h001, 1'b0, "busy_before_e10");
    rd(ADDR_CTRL, 32'h100, 32'h100, 1'b0, "done_after_e10");
    rd(ADDR_RESULT, 32'd100, 32'd100, 1'b0, "gauss_uniform");

    // Gaussian single bright centre: truncate vs round
    load9(32'd255, 32'd0);
    wr(ADDR_CTRL, 32'h01);
    idle(10);
    rd(ADDR_RESULT, 32'd63, 32'd64, 1'b0, "gauss_centre");
    rd(ADDR_CTRL, 32'h100, 32'h100, 1'b0, "gauss_centre_ctrl");

    // edge mode
    load9(32'd10, 32'd0);
    wr(ADDR_CTRL, 32'h05);
    idle(10);
    rd(ADDR_RESULT, 32'd80, 32'd80, 1'b0, "edge_centre10");
    rd(ADDR_CTRL, 32'h104, 32'h104, 1'b0, "edge_ctrl");

    load9(32'd0, 32'd255);
    wr(ADDR_CTRL, 32'h05);
    idle(10);
    rd(ADDR_RESULT, 32'd255, 32'd2040, 1'b0, "edge_neg_sat");

    load9(32'd4095, 32'd0);
    wr(ADDR_CTRL, 32'h05);
    idle(10);
    rd(ADDR_RESULT, 32'd255, 32'd4095, 1'b0, "edge_pos_sat");

    // identity and reserved mode
    load9(32'd77, 32'd200);
    wr(ADDR_CTRL, 32'h03);
    idle(10);
    rd(ADDR_RESULT, 32'd77, 32'd77, 1'b0, "ident");
    rd(ADDR_CTRL, 32'h102, 32'h102, 1'b0, "ident_ctrl");
    wr(ADDR_CTRL, 32'h07);
    idle(10);
    rd(ADDR_RESULT, 32'd77, 32'd77, 1'b0, "mode3");
    rd(ADDR_CTRL, 32'h106, 32'h106, 1'b0, "mode3_ctrl");

    // pointer wrap and clear
    for (int i = 1; i <= 11; i++) wr(ADDR_DATA, 32'(i));
    rd(ADDR_CTRL, 32'h2106, 32'h2106, 1'b0, "ptr_wrap");
    rd(ADDR_DATA, 32'd3, 32'd3, 1'b0, "data_at_ptr2");
    wr(ADDR_CTRL, 32'h08);
    rd(ADDR_CTRL, 32'h0106, 32'h0106, 1'b0, "clr_ptr");
    rd(ADDR_DATA, 32'd10, 32'd10, 1'b0, "w0_overwritten");

    // busy rules: DATA write and second start ignored
    load9(32'd50, 32'd7);
    wr(ADDR_CTRL, 32'h03);
    wr(ADDR_DATA, 32'd99);
    wr(ADDR_CTRL, 32'h05);
    idle(7);
    rd(ADDR_CTRL, 32'h003, 32'h003, 1'b0, "busy_ignore_ctrl");
    rd(ADDR_RESULT, 32'd50, 32'd50, 1'b0, "busy_ignore_result");
    rd(ADDR_CTRL, 32'h102, 32'h102, 1'b0, "busy_ignore_done");
    rd(ADDR_DATA, 32'd7, 32'd7, 1'b0, "busy_ignore_data");
    wr(ADDR_CTRL, 32'h20);
    idle(12);
    rd(ADDR_CTRL, 32'h002, 32'h002, 1'b0, "single_completion");

    // interrupt and done
    wr(ADDR_CTRL, 32'h10);
    rd(ADDR_CTRL, 32'h012, 32'h012, 1'b0, "irq_en_set");
    wr(ADDR_CTRL, 32'h11);
    idle(10);
    rd(ADDR_CTRL, 32'h110, 32'h110, 1'b1, "irq_raised");
    rd(ADDR_RESULT, 32'd17, 32'd18, 1'b1, "gauss_mixed");
    wr(ADDR_CTRL, 32'h30);
    rd(ADDR_CTRL, 32'h010, 32'h010, 1'b0, "irq_cleared");

    wr(ADDR_CTRL, 32'h11);
    idle(9);
    wr(ADDR_CTRL, 32'h30);
    rd(ADDR_CTRL, 32'h110, 32'h110, 1'b1, "done_clr_on_completion");

    // start + clr_ptr + done_clr together
    wr(ADDR_DATA, 32'd100);
    rd(ADDR_CTRL, 32'h1110, 32'h1110, 1'b1, "ptr_one");
    wr(ADDR_CTRL, 32'h29);
    rd(ADDR_CTRL, 32'h001, 32'h001, 1'b0, "start_clr_combo");
    idle(9);
    rd(ADDR_CTRL, 32'h100, 32'h100, 1'b0, "combo_done");
    rd(ADDR_RESULT, 32'd23, 32'd24, 1'b0, "combo_result");

    // reset mid-run at E5
    wr(ADDR_CTRL, 32'h11);
    idle(4);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rd(ADDR_CTRL,   32'h0, 32'h0, 1'b0, "midrst_ctrl");
    rd(ADDR_RESULT, 32'h0, 32'h0, 1'b0, "midrst_result");
    rd(ADDR_DATA,   32'h0, 32'h0, 1'b0, "midrst_data");
    rd(2'd3,        32'h0, 32'h0, 1'b0, "midrst_addr3");
    idle(12);
    rd(ADDR_CTRL,   32'h0, 32'h0, 1'b0, "midrst_no_run");

    // recovery run after reset
    load9(32'd100, 32'd100);
    wr(ADDR_CTRL, 32'h01);
    idle(10);
    rd(ADDR_RESULT, 32'd100, 32'd100, 1'b0, "post_rst_result");
    rd(ADDR_CTRL, 32'h100, 32'h100, 1'b0, "post_rst_ctrl");

    // report
    if (exp_q.size() != 0) begin
      checks_total++;
      $display("FAIL drain: %0d expected reads never presented, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
